dnoc_itf_core_rd_ctrl: RTL and testbench
========================================

// Module: dnoc_itf_core_rd_ctrl
// PURPOSE
//  Core-side read engine; the mirror of the core write path. Streams one granted read transaction into the core input port.
//  Local mode: reads L2 dmem through a 4-level loop address generator, with optional ping/pong buffer consumption.
//  Remote mode: takes a NoC grant, accepts the NoC read-data stream and returns a response pulse after the last beat.
//  Every beat passes through a FIFO, so core backpressure never drops data.
// PARAMETERS
//  DATA_W      256  data beat width
//  ADDR_W      13   L2 dmem word address width
//  FIFO_DEPTH  4    output FIFO entries (power of 2, >=2)
// PORTS
//  clk                      in  1        clock
//  rst_n                    in  1        synchronous active-low reset
//  core_cmd_core_rd_req     in  1        core read command request
//  core_cmd_core_rd_gnt     out 1        1-cycle grant of the command
//  c_cfg_c_r_base_addr      in  2x13     [0] ping base, [1] pong base
//  c_cfg_c_r_ping_lenth     in  13       ping/remote beats minus 1
//  c_cfg_c_r_pong_lenth     in  13       pong beats minus 1
//  c_cfg_c_r_pingpong_en    in  1        ping/pong mode
//  c_cfg_c_r_pingpong_num   in  11       number of ping+pong pairs
//  c_cfg_c_r_local_access   in  1        1=L2 dmem, 0=NoC
//  c_cfg_c_r_loop_lenth     in  4x13     per-level count minus 1
//  c_cfg_c_r_loop_gap       in  4x13     per-level address increment
//  pingpong_state           in  2        bit i=1: buffer i full/readable
//  pingpong_rd_done         out 1        pulse: one buffer fully delivered
//  c_r_transaction_done     out 1        pulse: transaction complete
//  L2_dmem_core_rd_en       out 1        dmem read enable
//  L2_dmem_core_rd_addr     out 13       dmem read address
//  L2_dmem_core_rd_data     in  256      dmem data, valid 1 cycle after en
//  core_rd_noc_out_req      out 1        NoC read channel request
//  core_rd_noc_out_gnt      in  1        NoC channel grant
//  noc_in_core_rd_data      in  256      NoC read data
//  noc_in_core_rd_valid     in  1        NoC data valid
//  noc_in_core_rd_ready     out 1        = FIFO not full, in NOC_RD only
//  core_rd_noc_resp         out 1        pulse: remote read complete
//  core_in_data             out 256      FIFO head
//  core_in_valid            out 1        FIFO not empty
//  core_in_ready            in  1        core accepts beat
// BEHAVIOUR
//  Reset (sync): FSM=IDLE; counters, FIFO, in-flight flag and all control outputs 0; core_in_data X.
//  FSM states: IDLE, NOC_RD_REQ, NOC_RD, NOC_RD_RESP, PP_CHECK, PING_RD, PONG_RD, DRAIN.
//  IDLE+req:
//   -local, !pingpong_en: gnt=1, addrgen<=base[0], ->PING_RD.
//   -local, pingpong_en: no gnt, pp_cnt=0, ->PP_CHECK.
//   -!local: ->NOC_RD_REQ.
//  NOC_RD_REQ: noc_out_req=1 until gnt; on gnt pulse core gnt, ->NOC_RD.
//  NOC_RD: count handshakes (valid&ready); beat ping_lenth+1 -> NOC_RD_RESP, cnt=0.
//  NOC_RD_RESP: wait FIFO empty -> core_rd_noc_resp=1 and c_r_transaction_done=1 same cycle, ->IDLE.
//  PP_CHECK: pp_cnt==2*num -> done pulse, pp_cnt=0, ->IDLE (num=0: done one cycle after entry).
//   Else needs req & pingpong_state[pp_cnt[0]]: gnt=1, addrgen<=base[pp_cnt[0]], pp_cnt++, ->PING_RD/PONG_RD.
//  PING/PONG_RD: issue rd_en when occupancy+in_flight<FIFO_DEPTH; addr=addrgen; beats=len+1; after last issue ->DRAIN.
//  DRAIN: wait FIFO empty and no read in flight.
//   -pingpong: pingpong_rd_done=1, ->PP_CHECK.
//   -non-pingpong: c_r_transaction_done=1, ->IDLE.
//  Read data pushed into FIFO the cycle after rd_en; credit check guarantees no overflow.
//  Addrgen: per issued beat, smallest k with lcnt[k]!=lenth[k]: lcnt[k]++, lcnt[j<k]=0, addr+=gap[k], mod 2^13 wrap.
//   All levels at lenth: counters clear, addr+=gap[3].
//  FIFO: simultaneous push+pop at full and empty both legal; occupancy unchanged; order preserved.
//  Core stall (ready=0) holds core_in_data/valid stable.
//  cfg sampled live; must be stable from IDLE exit to done.
// TESTING
//  Local, no pp, ping_lenth=7, lenth0=7 gap0=1, base0=0x100, ready=1:
//   -> addrs 0x100..0x107, 8 beats in order, one done pulse.
//  Same, core_in_ready toggling 1/0:
//   -> rd_en throttled, never >4 outstanding, no loss or duplication.
//  Loops lenth0=1 gap0=1, lenth1=2 gap1=0x10, ping_lenth=5, base 0:
//   -> addrs 0,1,0x11,0x12,0x22,0x23.
//  pp_en, num=2, lens 3/3, state=2'b00 then 01, later 10:
//   -> no gnt while empty; ping,pong,ping,pong; 4 rd_done pulses, then done.
//  Remote, ping_lenth=3, gnt after 3 cycles, noc valid bursty, core_ready=0 for 10 cycles:
//   -> noc ready drops when FIFO full, 4 beats delivered, resp+done once.
//  rst_n low mid-PING_RD:
//   -> next cycle FSM IDLE, FIFO empty, all outputs 0; fresh transaction works.

Source files
------------

// File: rtl/dnoc_itf_core_rd_ctrl.sv
// Core-side read engine: streams one granted read (local L2 dmem or remote NoC)
// into the core input port through a small credit-checked output FIFO.
//
// state         | meaning
// IDLE          | waiting for a core read command
// NOC_RD_REQ    | requesting the NoC read channel
// NOC_RD        | accepting NoC read beats into the FIFO
// NOC_RD_RESP   | waiting for the FIFO to empty, then respond and finish
// PP_CHECK      | ping/pong: pick the next full buffer or finish
// PING_RD       | issuing dmem reads for the ping (or single) buffer
// PONG_RD       | issuing dmem reads for the pong buffer
// DRAIN         | waiting for the last read to leave the FIFO
module dnoc_itf_core_rd_ctrl #(
  parameter int DATA_W     = 256,
  parameter int ADDR_W     = 13,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   core_cmd_core_rd_req,
  output logic                   core_cmd_core_rd_gnt,
  input  logic [1:0][ADDR_W-1:0] c_cfg_c_r_base_addr,
  input  logic [ADDR_W-1:0]      c_cfg_c_r_ping_lenth,
  input  logic [ADDR_W-1:0]      c_cfg_c_r_pong_lenth,
  input  logic                   c_cfg_c_r_pingpong_en,
  input  logic [10:0]            c_cfg_c_r_pingpong_num,
  input  logic                   c_cfg_c_r_local_access,
  input  logic [3:0][ADDR_W-1:0] c_cfg_c_r_loop_lenth,
  input  logic [3:0][ADDR_W-1:0] c_cfg_c_r_loop_gap,
  input  logic [1:0]             pingpong_state,
  output logic                   pingpong_rd_done,
  output logic                   c_r_transaction_done,
  output logic                   L2_dmem_core_rd_en,
  output logic [ADDR_W-1:0]      L2_dmem_core_rd_addr,
  input  logic [DATA_W-1:0]      L2_dmem_core_rd_data,
  output logic                   core_rd_noc_out_req,
  input  logic                   core_rd_noc_out_gnt,
  input  logic [DATA_W-1:0]      noc_in_core_rd_data,
  input  logic                   noc_in_core_rd_valid,
  output logic                   noc_in_core_rd_ready,
  output logic                   core_rd_noc_resp,
  output logic [DATA_W-1:0]      core_in_data,
  output logic                   core_in_valid,
  input  logic                   core_in_ready
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] BEAT_ONE = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_NOC_RD_REQ,
    S_NOC_RD,
    S_NOC_RD_RESP,
    S_PP_CHECK,
    S_PING_RD,
    S_PONG_RD,
    S_DRAIN
  } state_t;

  state_t state_q, state_d;
  logic [ADDR_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [11:0]       pp_cnt_q, pp_cnt_d;
  logic              in_flight_q;
  logic [ADDR_W-1:0] cur_len;

  logic              ag_load;
  logic [ADDR_W-1:0] ag_load_base;
  logic [ADDR_W-1:0] ag_addr_q, ag_addr_d;
  logic [3:0][ADDR_W-1:0] ag_lcnt_q, ag_lcnt_d;
  logic [1:0]        ag_k;
  logic              ag_found;

  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  fifo_cnt_q;
  logic              fifo_full, fifo_empty;
  logic              fifo_push, fifo_pop;
  logic [DATA_W-1:0] fifo_push_data;
  logic [CNT_W:0]    credit_used;
  logic              issue_ok;

  assign fifo_full   = (fifo_cnt_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty  = (fifo_cnt_q == '0);
  assign credit_used = {1'b0, fifo_cnt_q} + {{CNT_W{1'b0}}, in_flight_q};
  assign issue_ok    = (credit_used < (CNT_W+1)'(FIFO_DEPTH));
  assign cur_len     = (state_q == S_PONG_RD) ? c_cfg_c_r_pong_lenth : c_cfg_c_r_ping_lenth;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      beat_cnt_q  <= '0;
      pp_cnt_q    <= '0;
      in_flight_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      pp_cnt_q    <= pp_cnt_d;
      in_flight_q <= L2_dmem_core_rd_en;
    end
  end

  always_comb begin
    state_d              = state_q;
    beat_cnt_d           = beat_cnt_q;
    pp_cnt_d             = pp_cnt_q;
    core_cmd_core_rd_gnt = 1'b0;
    pingpong_rd_done     = 1'b0;
    c_r_transaction_done = 1'b0;
    L2_dmem_core_rd_en   = 1'b0;
    core_rd_noc_out_req  = 1'b0;
    noc_in_core_rd_ready = 1'b0;
    core_rd_noc_resp     = 1'b0;
    ag_load              = 1'b0;
    ag_load_base         = c_cfg_c_r_base_addr[0];
    case (state_q)
      S_IDLE: begin
        if (core_cmd_core_rd_req) begin
          if (!c_cfg_c_r_local_access) begin
            state_d = S_NOC_RD_REQ;
          end else if (c_cfg_c_r_pingpong_en) begin
            pp_cnt_d = '0;
            state_d  = S_PP_CHECK;
          end else begin
            core_cmd_core_rd_gnt = 1'b1;
            ag_load              = 1'b1;
            state_d              = S_PING_RD;
          end
        end
      end
      S_NOC_RD_REQ: begin
        core_rd_noc_out_req = 1'b1;
        if (core_rd_noc_out_gnt) begin
          core_cmd_core_rd_gnt = 1'b1;
          state_d              = S_NOC_RD;
        end
      end
      S_NOC_RD: begin
        noc_in_core_rd_ready = !fifo_full;
        if (noc_in_core_rd_valid && !fifo_full) begin
          if (beat_cnt_q == c_cfg_c_r_ping_lenth) begin
            beat_cnt_d = '0;
            state_d    = S_NOC_RD_RESP;
          end else begin
            beat_cnt_d = beat_cnt_q + BEAT_ONE;
          end
        end
      end
      S_NOC_RD_RESP: begin
        if (fifo_empty) begin
          core_rd_noc_resp     = 1'b1;
          c_r_transaction_done = 1'b1;
          state_d              = S_IDLE;
        end
      end
      S_PP_CHECK: begin
        if (pp_cnt_q == {c_cfg_c_r_pingpong_num, 1'b0}) begin
          c_r_transaction_done = 1'b1;
          pp_cnt_d             = '0;
          state_d              = S_IDLE;
        end else if (core_cmd_core_rd_req && pingpong_state[pp_cnt_q[0]]) begin
          core_cmd_core_rd_gnt = 1'b1;
          ag_load              = 1'b1;
          ag_load_base         = c_cfg_c_r_base_addr[pp_cnt_q[0]];
          pp_cnt_d             = pp_cnt_q + 12'd1;
          state_d              = pp_cnt_q[0] ? S_PONG_RD : S_PING_RD;
        end
      end
      S_PING_RD, S_PONG_RD: begin
        // one credit per FIFO slot, counting the read whose data lands next cycle
        if (issue_ok) begin
          L2_dmem_core_rd_en = 1'b1;
          if (beat_cnt_q == cur_len) begin
            beat_cnt_d = '0;
            state_d    = S_DRAIN;
          end else begin
            beat_cnt_d = beat_cnt_q + BEAT_ONE;
          end
        end
      end
      S_DRAIN: begin
        if (fifo_empty && !in_flight_q) begin
          if (c_cfg_c_r_pingpong_en) begin
            pingpong_rd_done = 1'b1;
            state_d          = S_PP_CHECK;
          end else begin
            c_r_transaction_done = 1'b1;
            state_d              = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The lowest level not yet at its count advances; if none, all wrap and level 3's gap applies.
  always_comb begin
    ag_k     = 2'd3;
    ag_found = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (ag_lcnt_q[k] != c_cfg_c_r_loop_lenth[k]) begin
        ag_k     = 2'(k);
        ag_found = 1'b1;
      end
    end
    ag_lcnt_d = ag_lcnt_q;
    for (int j = 0; j < 4; j++) begin
      if (!ag_found || (2'(j) < ag_k)) begin
        ag_lcnt_d[j] = '0;
      end else if (2'(j) == ag_k) begin
        ag_lcnt_d[j] = ag_lcnt_q[j] + BEAT_ONE;
      end
    end
    ag_addr_d = ag_addr_q + c_cfg_c_r_loop_gap[ag_k];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ag_addr_q <= '0;
      ag_lcnt_q <= '0;
    end else if (ag_load) begin
      ag_addr_q <= ag_load_base;
      ag_lcnt_q <= '0;
    end else if (L2_dmem_core_rd_en) begin
      ag_addr_q <= ag_addr_d;
      ag_lcnt_q <= ag_lcnt_d;
    end
  end

  assign L2_dmem_core_rd_addr = ag_addr_q;

  assign fifo_push      = in_flight_q || (noc_in_core_rd_ready && noc_in_core_rd_valid);
  assign fifo_push_data = in_flight_q ? L2_dmem_core_rd_data : noc_in_core_rd_data;
  assign fifo_pop       = core_in_valid && core_in_ready;

  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_mem[wr_ptr_q] <= fifo_push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (fifo_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (fifo_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  assign core_in_valid = !fifo_empty;
  assign core_in_data  = fifo_mem[rd_ptr_q];

endmodule

// File: tb/tb_dnoc_itf_core_rd_ctrl.sv
// Randomized bench for dnoc_itf_core_rd_ctrl: expected addresses come from a
// closed-form loop-count formula, data from an address-tagged dmem and a NoC source queue.
module tb_dnoc_itf_core_rd_ctrl;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                core_cmd_core_rd_req;
  logic                core_cmd_core_rd_gnt;
  logic [1:0][12:0]    c_cfg_c_r_base_addr;
  logic [12:0]         c_cfg_c_r_ping_lenth;
  logic [12:0]         c_cfg_c_r_pong_lenth;
  logic                c_cfg_c_r_pingpong_en;
  logic [10:0]         c_cfg_c_r_pingpong_num;
  logic                c_cfg_c_r_local_access;
  logic [3:0][12:0]    c_cfg_c_r_loop_lenth;
  logic [3:0][12:0]    c_cfg_c_r_loop_gap;
  logic [1:0]          pingpong_state;
  logic                pingpong_rd_done;
  logic                c_r_transaction_done;
  logic                L2_dmem_core_rd_en;
  logic [12:0]         L2_dmem_core_rd_addr;
  logic [255:0]        L2_dmem_core_rd_data;
  logic                core_rd_noc_out_req;
  logic                core_rd_noc_out_gnt;
  logic [255:0]        noc_in_core_rd_data;
  logic                noc_in_core_rd_valid;
  logic                noc_in_core_rd_ready;
  logic                core_rd_noc_resp;
  logic [255:0]        core_in_data;
  logic                core_in_valid;
  logic                core_in_ready;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dnoc_itf_core_rd_ctrl #(.DATA_W(256), .ADDR_W(13), .FIFO_DEPTH(4)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .core_cmd_core_rd_req  (core_cmd_core_rd_req),
    .core_cmd_core_rd_gnt  (core_cmd_core_rd_gnt),
    .c_cfg_c_r_base_addr   (c_cfg_c_r_base_addr),
    .c_cfg_c_r_ping_lenth  (c_cfg_c_r_ping_lenth),
    .c_cfg_c_r_pong_lenth  (c_cfg_c_r_pong_lenth),
    .c_cfg_c_r_pingpong_en (c_cfg_c_r_pingpong_en),
    .c_cfg_c_r_pingpong_num(c_cfg_c_r_pingpong_num),
    .c_cfg_c_r_local_access(c_cfg_c_r_local_access),
    .c_cfg_c_r_loop_lenth  (c_cfg_c_r_loop_lenth),
    .c_cfg_c_r_loop_gap    (c_cfg_c_r_loop_gap),
    .pingpong_state        (pingpong_state),
    .pingpong_rd_done      (pingpong_rd_done),
    .c_r_transaction_done  (c_r_transaction_done),
    .L2_dmem_core_rd_en    (L2_dmem_core_rd_en),
    .L2_dmem_core_rd_addr  (L2_dmem_core_rd_addr),
    .L2_dmem_core_rd_data  (L2_dmem_core_rd_data),
    .core_rd_noc_out_req   (core_rd_noc_out_req),
    .core_rd_noc_out_gnt   (core_rd_noc_out_gnt),
    .noc_in_core_rd_data   (noc_in_core_rd_data),
    .noc_in_core_rd_valid  (noc_in_core_rd_valid),
    .noc_in_core_rd_ready  (noc_in_core_rd_ready),
    .core_rd_noc_resp      (core_rd_noc_resp),
    .core_in_data          (core_in_data),
    .core_in_valid         (core_in_valid),
    .core_in_ready         (core_in_ready)
  );

  function automatic logic [255:0] mem_word(input logic [12:0] a);
    return {8{a, 3'b101, 16'h5A3C}};
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Beat n's address: level k advanced on every multiple of the product of lower
  // level sizes that is not also a multiple of the next product; level 3 on all its multiples.
  function automatic logic [12:0] exp_addr(input logic [12:0] base_a, input int n);
    longint p[5];
    longint sum;
    longint nn;
    nn = longint'(n);
    p[0] = 1;
    for (int k = 0; k < 4; k++) p[k+1] = p[k] * (longint'({19'd0, c_cfg_c_r_loop_lenth[k]}) + 1);
    sum = 0;
    for (int k = 0; k < 3; k++)
      sum += (nn / p[k] - nn / p[k+1]) * longint'({19'd0, c_cfg_c_r_loop_gap[k]});
    sum += (nn / p[3]) * longint'({19'd0, c_cfg_c_r_loop_gap[3]});
    sum = (longint'({19'd0, base_a}) + sum) & 64'h1FFF;
    return sum[12:0];
  endfunction

  always @(posedge clk)
    L2_dmem_core_rd_data <= L2_dmem_core_rd_en ? mem_word(L2_dmem_core_rd_addr) : {8{32'hDEADBEEF}};

  logic [12:0]  addr_q[$];
  logic [255:0] data_q[$];
  logic [255:0] noc_src[$];
  int issued, popped, max_out, gnt_cnt, done_cnt, rd_done_cnt, resp_cnt, both_cnt;
  int noc_hs, noc_req_cyc, full_block;

  always @(negedge clk) begin
    if (L2_dmem_core_rd_en) begin
      addr_q.push_back(L2_dmem_core_rd_addr);
      issued++;
      if (issued - popped > max_out) max_out = issued - popped;
    end
    if (core_in_valid && core_in_ready) begin
      data_q.push_back(core_in_data);
      popped++;
    end
    if (core_cmd_core_rd_gnt) gnt_cnt++;
    if (c_r_transaction_done) done_cnt++;
    if (pingpong_rd_done) rd_done_cnt++;
    if (core_rd_noc_resp) resp_cnt++;
    if (core_rd_noc_resp && c_r_transaction_done) both_cnt++;
    if (core_rd_noc_out_req) noc_req_cyc++;
    if (noc_in_core_rd_valid && noc_in_core_rd_ready) noc_hs++;
    if (noc_in_core_rd_valid && !noc_in_core_rd_ready) full_block++;
  end

  task automatic clear_mon();
    addr_q.delete(); data_q.delete();
    issued = 0; popped = 0; max_out = 0; gnt_cnt = 0; done_cnt = 0; rd_done_cnt = 0;
    resp_cnt = 0; both_cnt = 0; noc_hs = 0; noc_req_cyc = 0; full_block = 0;
  endtask

  // rmode: 0 ready=1, 1 toggling, 2 random, 3 stalled 10 cycles then mostly ready
  task automatic drive_txn(input int rmode, input bit pp, input int budget, output bit to, output int early_gnt);
    int pp_delay;
    int last_rdd;
    bit noc_gnt_given;
    to = 1'b1; early_gnt = 0; pp_delay = -1; last_rdd = 0; noc_gnt_given = 1'b0;
    core_cmd_core_rd_req = 1'b1;
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(posedge clk); #1;
      case (rmode)
        0:       core_in_ready = 1'b1;
        1:       core_in_ready = (cyc % 2 == 0);
        2:       core_in_ready = ($urandom % 2 == 0);
        default: core_in_ready = (cyc >= 10) && ($urandom % 4 != 0);
      endcase
      if (pp) begin
        if (cyc == 10) begin
          early_gnt = gnt_cnt;
          pingpong_state = 2'b01;
        end
        if (rd_done_cnt != last_rdd) begin
          last_rdd = rd_done_cnt;
          pingpong_state = 2'b00;
          pp_delay = $urandom_range(1, 5);
        end else if (pp_delay > 0) begin
          pp_delay--;
          if (pp_delay == 0) pingpong_state = (last_rdd % 2 == 1) ? 2'b10 : 2'b01;
        end
      end
      core_rd_noc_out_gnt = 1'b0;
      if (!noc_gnt_given && noc_req_cyc >= 3) begin
        core_rd_noc_out_gnt = 1'b1;
        noc_gnt_given = 1'b1;
      end
      if (noc_gnt_given && !core_rd_noc_out_gnt && noc_hs < noc_src.size()) begin
        noc_in_core_rd_valid = (cyc < 14) || ($urandom % 3 != 0);
        noc_in_core_rd_data  = noc_src[noc_hs];
      end else begin
        noc_in_core_rd_valid = 1'b0;
        noc_in_core_rd_data  = rnd256();
      end
      if (done_cnt > 0) begin
        to = 1'b0;
        break;
      end
    end
    core_cmd_core_rd_req = 1'b0;
    pingpong_state = 2'b00;
    noc_in_core_rd_valid = 1'b0;
    core_rd_noc_out_gnt = 1'b0;
    core_in_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic set_linear(input logic [12:0] b0, input logic [12:0] len);
    c_cfg_c_r_base_addr    = {13'h0, b0};
    c_cfg_c_r_ping_lenth   = len;
    c_cfg_c_r_pong_lenth   = len;
    c_cfg_c_r_pingpong_en  = 1'b0;
    c_cfg_c_r_pingpong_num = '0;
    c_cfg_c_r_local_access = 1'b1;
    c_cfg_c_r_loop_lenth   = {13'd0, 13'd0, 13'd0, len};
    c_cfg_c_r_loop_gap     = {13'd0, 13'd0, 13'd0, 13'd1};
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if ({core_cmd_core_rd_gnt, pingpong_rd_done, c_r_transaction_done, L2_dmem_core_rd_en,
         core_rd_noc_out_req, noc_in_core_rd_ready, core_rd_noc_resp, core_in_valid} !== 8'h00) begin
      n_err++;
      $display("FAIL reset_outputs: got %b want 00000000", {core_cmd_core_rd_gnt, pingpong_rd_done,
               c_r_transaction_done, L2_dmem_core_rd_en, core_rd_noc_out_req, noc_in_core_rd_ready,
               core_rd_noc_resp, core_in_valid});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_local_stream(input string tag, input int rmode);
    bit to;
    int eg;
    int nb;
    logic [12:0]  ea;
    logic [12:0]  ga;
    logic [255:0] gd;
    nb = int'(c_cfg_c_r_ping_lenth) + 1;
    clear_mon();
    drive_txn(rmode, 1'b0, 2000, to, eg);
    n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL %s_timeout: done not seen", tag); end
    n_cmp++; if (addr_q.size() != nb) begin n_err++; $display("FAIL %s_nreads: got %0d want %0d", tag, addr_q.size(), nb); end
    n_cmp++; if (data_q.size() != nb) begin n_err++; $display("FAIL %s_nbeats: got %0d want %0d", tag, data_q.size(), nb); end
    for (int i = 0; i < nb; i++) begin
      ea = exp_addr(c_cfg_c_r_base_addr[0], i);
      ga = (i < addr_q.size()) ? addr_q[i] : 13'bx;
      gd = (i < data_q.size()) ? data_q[i] : 256'bx;
      n_cmp++; if (ga !== ea) begin n_err++; $display("FAIL %s_addr[%0d]: got %h want %h", tag, i, ga, ea); end
      n_cmp++; if (gd !== mem_word(ea)) begin n_err++; $display("FAIL %s_data[%0d]: got %h want %h", tag, i, gd[31:0], mem_word(ea) & 256'hFFFFFFFF); end
    end
    n_cmp++; if (gnt_cnt != 1) begin n_err++; $display("FAIL %s_gnt: got %0d want 1", tag, gnt_cnt); end
    n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL %s_done: got %0d want 1", tag, done_cnt); end
    n_cmp++; if (rd_done_cnt != 0) begin n_err++; $display("FAIL %s_rd_done: got %0d want 0", tag, rd_done_cnt); end
    n_cmp++; if (max_out > 4) begin n_err++; $display("FAIL %s_outstanding: got %0d want <=4", tag, max_out); end
  endtask

  task automatic test_linear();
    set_linear(13'h100, 13'd7);
    test_local_stream("linear", 0);
  endtask

  task automatic test_stall();
    set_linear(13'h100, 13'd7);
    test_local_stream("stall_toggle", 1);
    set_linear(13'(13'h1FF0 + $urandom_range(0, 15)), 13'(19));
    test_local_stream("stall_random", 2);
  endtask

  task automatic test_loops();
    set_linear(13'h0, 13'd5);
    c_cfg_c_r_loop_lenth = {13'd0, 13'd0, 13'd2, 13'd1};
    c_cfg_c_r_loop_gap   = {13'd0, 13'd0, 13'h10, 13'd1};
    test_local_stream("loops_fixed", 0);
    for (int r = 0; r < 4; r++) begin
      set_linear(13'($urandom), 13'($urandom_range(4, 30)));
      for (int k = 0; k < 4; k++) begin
        c_cfg_c_r_loop_lenth[k] = 13'($urandom_range(0, 2));
        c_cfg_c_r_loop_gap[k]   = 13'($urandom);
      end
      test_local_stream("loops_random", 2);
    end
  endtask

  task automatic test_pingpong();
    bit to;
    int eg;
    logic [12:0]  ea;
    logic [12:0]  ga;
    logic [255:0] gd;
    set_linear(13'h200, 13'd3);
    c_cfg_c_r_base_addr    = {13'h300, 13'h200};
    c_cfg_c_r_pingpong_en  = 1'b1;
    c_cfg_c_r_pingpong_num = 11'd2;
    clear_mon();
    drive_txn(2, 1'b1, 1000, to, eg);
    n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL pp_timeout: done not seen"); end
    n_cmp++; if (eg != 0) begin n_err++; $display("FAIL pp_early_gnt: got %0d want 0", eg); end
    n_cmp++; if (gnt_cnt != 4) begin n_err++; $display("FAIL pp_gnt: got %0d want 4", gnt_cnt); end
    n_cmp++; if (rd_done_cnt != 4) begin n_err++; $display("FAIL pp_rd_done: got %0d want 4", rd_done_cnt); end
    n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL pp_done: got %0d want 1", done_cnt); end
    n_cmp++; if (addr_q.size() != 16) begin n_err++; $display("FAIL pp_nreads: got %0d want 16", addr_q.size()); end
    for (int i = 0; i < 16; i++) begin
      ea = exp_addr(c_cfg_c_r_base_addr[(i / 4) % 2], i % 4);
      ga = (i < addr_q.size()) ? addr_q[i] : 13'bx;
      gd = (i < data_q.size()) ? data_q[i] : 256'bx;
      n_cmp++; if (ga !== ea) begin n_err++; $display("FAIL pp_addr[%0d]: got %h want %h", i, ga, ea); end
      n_cmp++; if (gd !== mem_word(ea)) begin n_err++; $display("FAIL pp_data[%0d]: got %h want %h", i, gd[31:0], mem_word(ea) & 256'hFFFFFFFF); end
    end
    c_cfg_c_r_pingpong_num = 11'd0;
    clear_mon();
    drive_txn(0, 1'b1, 50, to, eg);
    n_cmp++; if (to !== 1'b0 || done_cnt != 1) begin n_err++; $display("FAIL pp_zero_done: got %0d want 1", done_cnt); end
    n_cmp++; if (gnt_cnt != 0 || issued != 0) begin n_err++; $display("FAIL pp_zero_idle: got gnt %0d reads %0d want 0 0", gnt_cnt, issued); end
    c_cfg_c_r_pingpong_en = 1'b0;
  endtask

  task automatic test_remote(input string tag, input int len);
    bit to;
    int eg;
    logic [255:0] gd;
    set_linear(13'h0, 13'(len));
    c_cfg_c_r_local_access = 1'b0;
    noc_src.delete();
    for (int i = 0; i <= len; i++) noc_src.push_back(rnd256());
    clear_mon();
    drive_txn(3, 1'b0, 1000, to, eg);
    n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL %s_timeout: done not seen", tag); end
    n_cmp++; if (noc_req_cyc != 4) begin n_err++; $display("FAIL %s_noc_req: got %0d want 4", tag, noc_req_cyc); end
    n_cmp++; if (gnt_cnt != 1) begin n_err++; $display("FAIL %s_gnt: got %0d want 1", tag, gnt_cnt); end
    n_cmp++; if (resp_cnt != 1 || both_cnt != 1) begin n_err++; $display("FAIL %s_resp: got resp %0d joint %0d want 1 1", tag, resp_cnt, both_cnt); end
    n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL %s_done: got %0d want 1", tag, done_cnt); end
    n_cmp++; if (issued != 0) begin n_err++; $display("FAIL %s_dmem: got %0d want 0", tag, issued); end
    n_cmp++; if (data_q.size() != len + 1) begin n_err++; $display("FAIL %s_nbeats: got %0d want %0d", tag, data_q.size(), len + 1); end
    for (int i = 0; i <= len; i++) begin
      gd = (i < data_q.size()) ? data_q[i] : 256'bx;
      n_cmp++; if (gd !== noc_src[i]) begin n_err++; $display("FAIL %s_data[%0d]: got %h want %h", tag, i, gd[31:0], noc_src[i] & 256'hFFFFFFFF); end
    end
    if (len > 3) begin
      n_cmp++; if (full_block == 0) begin n_err++; $display("FAIL %s_backpressure: got 0 blocked cycles want >0", tag); end
    end
    c_cfg_c_r_local_access = 1'b1;
  endtask

  task automatic test_reset_mid();
    bit seen;
    set_linear(13'h40, 13'd15);
    clear_mon();
    seen = 1'b0;
    core_in_ready = 1'b0;
    core_cmd_core_rd_req = 1'b1;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk); #1;
      seen = (gnt_cnt > 0);
    end
    n_cmp++; if (!seen) begin n_err++; $display("FAIL rstmid_gnt: got 0 want 1"); end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    core_cmd_core_rd_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({core_cmd_core_rd_gnt, pingpong_rd_done, c_r_transaction_done, L2_dmem_core_rd_en,
         core_rd_noc_out_req, noc_in_core_rd_ready, core_rd_noc_resp, core_in_valid} !== 8'h00) begin
      n_err++;
      $display("FAIL rstmid_outputs: got %b want 00000000", {core_cmd_core_rd_gnt, pingpong_rd_done,
               c_r_transaction_done, L2_dmem_core_rd_en, core_rd_noc_out_req, noc_in_core_rd_ready,
               core_rd_noc_resp, core_in_valid});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    core_in_ready = 1'b1;
    @(posedge clk); #1;
    set_linear(13'h80, 13'd9);
    test_local_stream("rstmid_fresh", 2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    core_cmd_core_rd_req = 1'b0;
    core_in_ready = 1'b1;
    pingpong_state = 2'b00;
    core_rd_noc_out_gnt = 1'b0;
    noc_in_core_rd_valid = 1'b0;
    noc_in_core_rd_data = '0;
    set_linear(13'h0, 13'd0);
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_reset();
    test_linear();
    test_stall();
    test_loops();
    test_pingpong();
    test_remote("remote", 3);
    test_remote("remote_long", 11);
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
